// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, prefix-FSM state type and the IDLE discard list.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  // Pause lead-in and keyboard status/ack bytes carry no key information.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 base code to ASCII; upper selects capital letters only.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic       letter;

  always_comb begin
    base   = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      default: letter = 1'b0;
    endcase
    ascii = (letter && upper) ? base - 8'h20 : base;
    if (!letter) begin
      case (code)
        8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 byte stream to registered key events (make/break, ext, ASCII, repeat, press count).
// Optional caps-lock toggle on key 0x58 is enabled by defining PS2_CAPS_LOCK_EN.
module ps2_scan_decoder
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic [7:0] evt_ascii,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       evt_repeat,
  output logic       shift,
  output logic       caps,
  output logic [7:0] press_count
);

  state_t     state, state_nxt;
  logic       accept, emit, emit_ext, emit_brk;
  logic [7:0] held;
  logic       held_ext, shift_l, shift_r, is_repeat, held_match;
  logic [7:0] lut_ascii;

  assign code_ready = ~evt_valid | evt_ready;
  assign accept     = code_valid & code_ready;
  assign shift      = shift_l | shift_r;
  assign held_match = ({emit_ext, code} == {held_ext, held});
  assign is_repeat  = ~emit_brk & held_match;

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (code == PS2_EXT)      state_nxt = EXT;
          else if (code == PS2_BRK) state_nxt = BRK;
          else if (!is_discard(code)) emit = 1'b1;
        end
        EXT: begin
          if (code == PS2_BRK) state_nxt = EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          emit      = 1'b1;
          emit_brk  = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          emit      = 1'b1;
          emit_brk  = 1'b1;
          emit_ext  = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Modifier state seen here is the value before this byte's own effect.
  ps2_ascii_lut u_lut (
    .code  (code),
    .upper (shift ^ caps),
    .ascii (lut_ascii)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      evt_valid   <= 1'b0;
      evt_code    <= 8'h00;
      evt_ascii   <= 8'h00;
      evt_break   <= 1'b0;
      evt_ext     <= 1'b0;
      evt_repeat  <= 1'b0;
      held        <= 8'h00;
      held_ext    <= 1'b0;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      press_count <= 8'h00;
    end else begin
      state <= state_nxt;
      if (emit) begin
        evt_valid  <= 1'b1;
        evt_code   <= code;
        evt_ascii  <= emit_ext ? 8'h00 : lut_ascii;
        evt_break  <= emit_brk;
        evt_ext    <= emit_ext;
        evt_repeat <= is_repeat;
        if (!emit_brk) begin
          if (!is_repeat) begin
            held        <= code;
            held_ext    <= emit_ext;
            press_count <= press_count + 8'd1;
          end
        end else if (held_match) begin
          held     <= 8'h00;
          held_ext <= 1'b0;
        end
        if (!emit_ext && code == PS2_LSHIFT) shift_l <= ~emit_brk;
        if (!emit_ext && code == PS2_RSHIFT) shift_r <= ~emit_brk;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

`ifdef PS2_CAPS_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) caps <= 1'b0;
    else if (emit && !emit_ext && !emit_brk && !is_repeat && code == PS2_CAPS) caps <= ~caps;
  end
`else
  assign caps = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomized and directed bench for ps2_scan_decoder against a behavioural event model.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code, evt_ascii, press_count;
  logic       evt_break, evt_ext, evt_repeat, shift, caps;

  always #5 clk = ~clk;

  ps2_scan_decoder dut (
    .clk (clk), .rst (rst), .code (code), .code_valid (code_valid), .code_ready (code_ready),
    .evt_valid (evt_valid), .evt_ready (evt_ready), .evt_code (evt_code), .evt_ascii (evt_ascii),
    .evt_break (evt_break), .evt_ext (evt_ext), .evt_repeat (evt_repeat), .shift (shift),
    .caps (caps), .press_count (press_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event word: {code, ascii, break, ext, repeat}
  function automatic logic [18:0] pk(input logic [7:0] c, input logic [7:0] a,
                                     input logic b, input logic e, input logic r);
    return {c, a, b, e, r};
  endfunction

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] discards [6] = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFF};

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input logic up);
    for (int i = 0; i < 26; i++)
      if (letters[i] == b) return up ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (digits[i] == b) return 8'(8'h30 + i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    if (b == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  logic        m_ext, m_brk, m_lsh, m_rsh, m_caps;
  logic [8:0]  m_held;
  logic [7:0]  m_press;
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_held = 0; m_press = 0;
    exp_q.delete();
  endtask

  task automatic model_emit(input logic [7:0] b, input logic e, input logic brk);
    logic [8:0] key;
    logic       rpt;
    logic [7:0] a;
    key = {e, b};
    rpt = !brk && key == m_held;
    a   = e ? 8'h00 : ref_ascii(b, (m_lsh | m_rsh) ^ m_caps);
    exp_q.push_back(pk(b, a, brk, e, rpt));
    if (!brk) begin
      if (!rpt) begin
        m_held = key;
        m_press++;
      end
    end else if (key == m_held) m_held = 0;
    if (!e && b == 8'h12) m_lsh = !brk;
    if (!e && b == 8'h59) m_rsh = !brk;
`ifdef PS2_CAPS_LOCK_EN
    if (!e && !brk && !rpt && b == 8'h58) m_caps = !m_caps;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFF})) model_emit(b, 0, 0);
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else begin model_emit(b, 1, 0); m_ext = 0; end
    end else begin
      model_emit(b, m_ext, 1);
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic observe();
    logic [18:0] cur;
    cur = pk(evt_code, evt_ascii, evt_break, evt_ext, evt_repeat);
    check("code_ready", code_ready, (exp_q.size() == 0) || evt_ready);
    check("evt_valid", evt_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("evt_fields", cur, exp_q[0]);
    check("shift", shift, m_lsh | m_rsh);
    check("caps", caps, m_caps);
    check("press_count", press_count, m_press);
    if (evt_valid && evt_ready) begin
      got_q.push_back(cur);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (code_valid && code_ready) model_byte(code);
  endtask

  task automatic run_bytes(input logic [7:0] bytes[$], input bit rnd, input int stall, input bit drain);
    int idx = 0;
    int guard = 0;
    int stall_left = stall;
    while (idx < bytes.size() || (drain && (exp_q.size() != 0 || evt_valid))) begin
      @(posedge clk); #1;
      if (guard++ > bytes.size() * 8 + 50) begin
        check("timeout", 1, 0);
        break;
      end
      code_valid = (idx < bytes.size()) && (!rnd || $urandom_range(3) != 0);
      code       = (idx < bytes.size()) ? bytes[idx] : 8'h00;
      if (rnd) evt_ready = 1'($urandom_range(1));
      else if (stall_left > 0 && evt_valid) begin
        evt_ready = 1'b0;
        stall_left--;
      end else evt_ready = 1'b1;
      #1;
      if (code_valid && code_ready) idx++;
      observe();
    end
    @(posedge clk); #1;
    code_valid = 1'b0;
    #1;
    observe();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("reset_outputs", {evt_valid, evt_code, evt_ascii, evt_break, evt_ext, evt_repeat,
                            shift, caps, press_count}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [18:0] gotf(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[$];
    model_reset();
    do_reset();

    seq = '{8'h1C, 8'hF0, 8'h1C};
    got_q.delete(); run_bytes(seq, 0, 0, 1);
    check("t1_make", gotf(0), pk(8'h1C, 8'h61, 0, 0, 0));
    check("t1_break", gotf(1), pk(8'h1C, 8'h61, 1, 0, 0));
    check("t1_press", press_count, 1);

    do_reset();
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    got_q.delete(); run_bytes(seq, 0, 0, 1);
    check("t2_upper", gotf(1), pk(8'h1C, 8'h41, 0, 0, 0));
    check("t2_count", got_q.size(), 4);
    check("t2_shift_off", shift, 0);

    do_reset();
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    got_q.delete(); run_bytes(seq, 0, 0, 1);
    check("t3_count", got_q.size(), 2);
    check("t3_make", gotf(0), pk(8'h75, 8'h00, 0, 1, 0));
    check("t3_break", gotf(1), pk(8'h75, 8'h00, 1, 1, 0));

    do_reset();
    seq = '{8'h1C, 8'h1C, 8'h1C};
    got_q.delete(); run_bytes(seq, 0, 0, 1);
    check("t4_repeat", {gotf(0)[0], gotf(1)[0], gotf(2)[0]}, 3'b011);
    check("t4_press", press_count, 1);

    do_reset();
    seq = '{8'h16, 8'h1E};
    got_q.delete(); run_bytes(seq, 0, 5, 1);
    check("t5_first", gotf(0), pk(8'h16, 8'h31, 0, 0, 0));
    check("t5_second", gotf(1), pk(8'h1E, 8'h32, 0, 0, 0));

    do_reset();
    seq = '{8'h58, 8'hF0, 8'h58, 8'h1C};
    got_q.delete(); run_bytes(seq, 0, 0, 1);
`ifdef PS2_CAPS_LOCK_EN
    check("t6_caps", gotf(2), pk(8'h1C, 8'h41, 0, 0, 0));
`else
    check("t6_caps", gotf(2), pk(8'h1C, 8'h61, 0, 0, 0));
`endif

    do_reset();
    seq = '{8'hF0};
    run_bytes(seq, 0, 0, 0);
    do_reset();
    seq = '{8'h1C};
    got_q.delete(); run_bytes(seq, 0, 0, 1);
    check("t7_make", gotf(0), pk(8'h1C, 8'h61, 0, 0, 0));
    check("t7_press", press_count, 1);

    for (int blk = 0; blk < 300; blk++) begin
      bit drain;
      seq.delete();
      for (int j = 0; j < int'($urandom_range(20, 1)); j++) begin
        case ($urandom_range(9))
          0: seq.push_back(8'hE0);
          1: seq.push_back(8'hF0);
          2: seq.push_back($urandom_range(1) ? 8'h12 : ($urandom_range(1) ? 8'h59 : 8'h58));
          3: seq.push_back(discards[$urandom_range(5)]);
          4, 5: seq.push_back(letters[$urandom_range(25)]);
          6: seq.push_back(digits[$urandom_range(9)]);
          7: seq.push_back($urandom_range(1) ? 8'h29 : ($urandom_range(1) ? 8'h5A : 8'h66));
          8: seq.push_back(8'($urandom));
          default: seq.push_back(8'h1C);
        endcase
      end
      drain = ($urandom_range(3) != 0);
      run_bytes(seq, 1, 0, drain);
      if (!drain || $urandom_range(9) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
